// File: rtl/pacman_pkg.sv
// Shared encodings, grid geometry and small helpers for the Pac-Man movement block.
package pacman_pkg;

  typedef enum logic [1:0] {
    DIR_L = 2'd0,
    DIR_R = 2'd1,
    DIR_U = 2'd2,
    DIR_D = 2'd3
  } dir_e;

  localparam int LEGAL_L   = 3;
  localparam int LEGAL_R   = 2;
  localparam int LEGAL_U   = 1;
  localparam int LEGAL_D   = 0;

  localparam int GRID_X0   = 150;
  localparam int GRID_Y0   = 34;
  localparam int CELL      = 60;
  localparam int CELL_MID  = 30;
  localparam int GRID_COLS = 8;
  localparam int GRID_ROWS = 8;

  // One axis of the position: grid index plus pixel offset inside the cell.
  typedef struct packed {
    logic [2:0] idx;
    logic [5:0] off;
  } axis_t;

  // L<->R and U<->D differ only in bit 0 of the encoding.
  function automatic dir_e reverse(input dir_e d);
    return dir_e'(d ^ 2'b01);
  endfunction

  function automatic logic [1:0] legal_idx(input dir_e d);
    case (d)
      DIR_L:   return 2'(LEGAL_L);
      DIR_R:   return 2'(LEGAL_R);
      DIR_U:   return 2'(LEGAL_U);
      default: return 2'(LEGAL_D);
    endcase
  endfunction

  // Move one axis by step pixels, carrying into the neighbouring cell.
  function automatic axis_t advance(input axis_t a, input logic neg, input int step);
    axis_t      r;
    logic [6:0] s;
    r = a;
    s = 7'(a.off) + 7'(step);
    if (neg) begin
      if (a.off < 6'(step)) begin
        r.off = a.off + 6'(CELL - step);
        r.idx = a.idx - 3'd1;
      end else begin
        r.off = a.off - 6'(step);
      end
    end else if (s >= 7'(CELL)) begin
      r.off = 6'(s - 7'(CELL));
      r.idx = a.idx + 3'd1;
    end else begin
      r.off = s[5:0];
    end
    return r;
  endfunction

  function automatic logic [9:0] pix(input int base, input logic [2:0] idx,
                                     input logic [5:0] off);
    return 10'(base) + 10'(idx) * 10'(CELL) + 10'(off);
  endfunction

endpackage

// File: rtl/pacman_dir_queue.sv
// Latches the highest-priority pressed direction until the mover consumes it.
module pacman_dir_queue
  import pacman_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic btn_l_i,
  input  logic btn_r_i,
  input  logic btn_u_i,
  input  logic btn_d_i,
  input  logic consume_i,
  output logic pend_valid_o,
  output dir_e pend_dir_o
);

  logic pend_valid_q, pend_valid_d;
  dir_e pend_dir_q, pend_dir_d;

  // Outputs are the post-button view so a same-cycle press can be taken on a tick.
  always_comb begin
    pend_valid_d = pend_valid_q;
    pend_dir_d   = pend_dir_q;
    if (btn_l_i) begin
      pend_valid_d = 1'b1;
      pend_dir_d   = DIR_L;
    end else if (btn_r_i) begin
      pend_valid_d = 1'b1;
      pend_dir_d   = DIR_R;
    end else if (btn_u_i) begin
      pend_valid_d = 1'b1;
      pend_dir_d   = DIR_U;
    end else if (btn_d_i) begin
      pend_valid_d = 1'b1;
      pend_dir_d   = DIR_D;
    end
  end

  assign pend_valid_o = pend_valid_d;
  assign pend_dir_o   = pend_dir_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_valid_q <= 1'b0;
      pend_dir_q   <= DIR_L;
    end else begin
      pend_valid_q <= pend_valid_d & ~consume_i;
      pend_dir_q   <= pend_dir_d;
    end
  end

endmodule

// File: rtl/pacman_mover.sv
// Owns Pac-Man's grid position: turns/stops at cell centres, steps once per tick.
module pacman_mover
  import pacman_pkg::*;
#(
  parameter int START_COL = 3,
  parameter int START_ROW = 6,
  parameter int STEP      = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       btn_l,
  input  logic       btn_r,
  input  logic       btn_u,
  input  logic       btn_d,
  input  logic [3:0] legal,
  output logic [9:0] xpos,
  output logic [9:0] ypos,
  output logic [1:0] dir,
  output logic       moving
);

  logic [2:0] col_q, col_d, row_q, row_d;
  logic [5:0] off_x_q, off_x_d, off_y_q, off_y_d;
  dir_e       dir_q, dir_d, step_dir;
  logic       moving_q, moving_d;
  logic [9:0] xpos_q, ypos_q;
  logic       consume, step_en, at_centre;
  logic       pend_valid;
  dir_e       pend_dir;
  axis_t      ax_x, ax_y;

  pacman_dir_queue u_queue (
    .clk          (clk),
    .rst          (rst),
    .btn_l_i      (btn_l),
    .btn_r_i      (btn_r),
    .btn_u_i      (btn_u),
    .btn_d_i      (btn_d),
    .consume_i    (consume),
    .pend_valid_o (pend_valid),
    .pend_dir_o   (pend_dir)
  );

  // Grid edges are walls whatever the lookup reports.
  function automatic logic can_go(input dir_e d, input logic [3:0] lg,
                                  input logic [2:0] c, input logic [2:0] r);
    logic edge_ok;
    case (d)
      DIR_L:   edge_ok = (c != 3'd0);
      DIR_R:   edge_ok = (c != 3'(GRID_COLS - 1));
      DIR_U:   edge_ok = (r != 3'd0);
      default: edge_ok = (r != 3'(GRID_ROWS - 1));
    endcase
    return edge_ok & lg[legal_idx(d)];
  endfunction

  assign at_centre = (off_x_q == 6'(CELL_MID)) && (off_y_q == 6'(CELL_MID));

  always_comb begin
    dir_d    = dir_q;
    moving_d = moving_q;
    consume  = 1'b0;
    step_en  = 1'b0;
    step_dir = dir_q;
    if (tick) begin
      if (at_centre) begin
        if (pend_valid && can_go(pend_dir, legal, col_q, row_q)) begin
          dir_d    = pend_dir;
          moving_d = 1'b1;
          consume  = 1'b1;
          step_en  = 1'b1;
          step_dir = pend_dir;
        end else if (moving_q && can_go(dir_q, legal, col_q, row_q)) begin
          step_en  = 1'b1;
        end else begin
          moving_d = 1'b0;
        end
      end else if (pend_valid && pend_dir == reverse(dir_q)) begin
        dir_d    = pend_dir;
        consume  = 1'b1;
        step_en  = 1'b1;
        step_dir = pend_dir;
      end else begin
        step_en  = 1'b1;
      end
    end
  end

  // Only the heading's axis moves; the other offset stays at the cell middle.
  always_comb begin
    ax_x = '{idx: col_q, off: off_x_q};
    ax_y = '{idx: row_q, off: off_y_q};
    if (step_en) begin
      case (step_dir)
        DIR_L:   ax_x = advance(ax_x, 1'b1, STEP);
        DIR_R:   ax_x = advance(ax_x, 1'b0, STEP);
        DIR_U:   ax_y = advance(ax_y, 1'b1, STEP);
        default: ax_y = advance(ax_y, 1'b0, STEP);
      endcase
    end
    col_d   = ax_x.idx;
    off_x_d = ax_x.off;
    row_d   = ax_y.idx;
    off_y_d = ax_y.off;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q    <= 3'(START_COL);
      row_q    <= 3'(START_ROW);
      off_x_q  <= 6'(CELL_MID);
      off_y_q  <= 6'(CELL_MID);
      dir_q    <= DIR_L;
      moving_q <= 1'b0;
      xpos_q   <= pix(GRID_X0, 3'(START_COL), 6'(CELL_MID));
      ypos_q   <= pix(GRID_Y0, 3'(START_ROW), 6'(CELL_MID));
    end else begin
      col_q    <= col_d;
      row_q    <= row_d;
      off_x_q  <= off_x_d;
      off_y_q  <= off_y_d;
      dir_q    <= dir_d;
      moving_q <= moving_d;
      xpos_q   <= pix(GRID_X0, col_d, off_x_d);
      ypos_q   <= pix(GRID_Y0, row_d, off_y_d);
    end
  end

  assign xpos   = xpos_q;
  assign ypos   = ypos_q;
  assign dir    = dir_q;
  assign moving = moving_q;

endmodule

// File: tb/tb_pacman_mover.sv
// Directed walk through turns, reversal, centre stops, edge guard and reset.
module tb_pacman_mover;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic       btn_l = 1'b0, btn_r = 1'b0, btn_u = 1'b0, btn_d = 1'b0;
  logic [3:0] legal = 4'b0000;
  logic [9:0] xpos, ypos;
  logic [1:0] dir;
  logic       moving;

  int total  = 0;
  int passed = 0;

  pacman_mover dut (
    .clk    (clk),
    .rst    (rst),
    .tick   (tick),
    .btn_l  (btn_l),
    .btn_r  (btn_r),
    .btn_u  (btn_u),
    .btn_d  (btn_d),
    .legal  (legal),
    .xpos   (xpos),
    .ypos   (ypos),
    .dir    (dir),
    .moving (moving)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic ticks(input int n);
    tick = 1'b1;
    repeat (n) cyc();
    tick = 1'b0;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  initial begin
    @(negedge clk);
    cyc();
    rst = 1'b0;
    chk("rst_x", xpos, 360);
    chk("rst_y", ypos, 424);
    chk("rst_dir", dir, 0);
    chk("rst_moving", moving, 0);
    chk("rst_pend", dut.u_queue.pend_valid_q, 0);

    // Start moving right from a stop
    legal = 4'b0100;
    btn_r = 1'b1;
    ticks(1);
    btn_r = 1'b0;
    chk("start_x", xpos, 362);
    chk("start_dir", dir, 1);
    chk("start_moving", moving, 1);
    chk("start_pend", dut.u_queue.pend_valid_q, 0);

    // Cross into column 4, then through its centre
    ticks(14);
    chk("wrap_x", xpos, 390);
    chk("wrap_col", dut.col_q, 4);
    chk("wrap_off", dut.off_x_q, 0);
    ticks(15);
    chk("centre4_x", xpos, 420);
    chk("centre4_moving", moving, 1);

    // Reverse mid-cell at col 5 off 10
    ticks(20);
    chk("pre_rev_x", xpos, 460);
    chk("pre_rev_off", dut.off_x_q, 10);
    btn_l = 1'b1;
    ticks(1);
    btn_l = 1'b0;
    chk("rev_dir", dir, 0);
    chk("rev_off", dut.off_x_q, 8);
    chk("rev_x", xpos, 458);
    chk("rev_pend", dut.u_queue.pend_valid_q, 0);

    // Back to col 4 centre, where L is illegal: stop
    ticks(19);
    chk("back_x", xpos, 420);
    chk("back_moving", moving, 1);
    ticks(5);
    chk("stop_l_x", xpos, 420);
    chk("stop_l_moving", moving, 0);

    // Perpendicular request waits for the next centre
    btn_r = 1'b1;
    ticks(1);
    btn_r = 1'b0;
    chk("restart_x", xpos, 422);
    btn_u = 1'b1;
    cyc();
    btn_u = 1'b0;
    chk("perp_pend", dut.u_queue.pend_valid_q, 1);
    chk("perp_hold_x", xpos, 422);
    ticks(29);
    chk("perp_x", xpos, 480);
    chk("perp_dir", dir, 1);
    chk("perp_pend2", dut.u_queue.pend_valid_q, 1);
    legal = 4'b0110;
    ticks(1);
    chk("turn_dir", dir, 2);
    chk("turn_y", ypos, 422);
    chk("turn_x", xpos, 480);
    chk("turn_pend", dut.u_queue.pend_valid_q, 0);

    // Mid-cell ignores legal; at centre legal=0 stops
    legal = 4'b0000;
    ticks(29);
    chk("up_y", ypos, 364);
    chk("up_moving", moving, 1);
    ticks(5);
    chk("stop0_y", ypos, 364);
    chk("stop0_x", xpos, 480);
    chk("stop0_moving", moving, 0);

    // Run to col 7; edge guard stops despite legal[R]
    legal = 4'b0100;
    btn_r = 1'b1;
    ticks(1);
    btn_r = 1'b0;
    chk("go7_x", xpos, 482);
    ticks(59);
    chk("col7_x", xpos, 600);
    chk("col7_moving", moving, 1);
    ticks(5);
    chk("edge_x", xpos, 600);
    chk("edge_moving", moving, 0);

    // Illegal request is kept pending
    btn_u = 1'b1;
    ticks(1);
    btn_u = 1'b0;
    chk("keep_pend", dut.u_queue.pend_valid_q, 1);
    chk("keep_y", ypos, 364);
    legal = 4'b0010;
    ticks(1);
    chk("late_turn_y", ypos, 362);
    chk("late_turn_dir", dir, 2);

    // Reset mid-cell
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("mrst_x", xpos, 360);
    chk("mrst_y", ypos, 424);
    chk("mrst_dir", dir, 0);
    chk("mrst_moving", moving, 0);
    chk("mrst_pend", dut.u_queue.pend_valid_q, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
